// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, address field positions and issue register layout
package mem_pkg;
  localparam int ADDR_W        = 39;
  localparam int LINE_W        = 533;
  localparam int ADDR_SHARE_BIT = 37;
  localparam int ADDR_LINE_HI  = 36;
  localparam int ADDR_LINE_LO  = 4;
  localparam int ADDR_XDATA_HI = 3;
  localparam int ADDR_XDATA_LO = 0;
  localparam int MEM_LAT       = 48;

  typedef struct packed {
    logic              rden;
    logic              wren;
    logic [ADDR_W-1:0] rdaddr;
    logic [ADDR_W-1:0] wraddr;
    logic [LINE_W-1:0] wrdata;
  } issue_t;
endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - synchronous FIFO with occupancy count; head is visible one cycle after the write
module req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [W-1:0]            pop_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  slots [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A pop frees the slot in the same cycle, so a push at full still lands.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr_q] <= push_data;
  end

  assign pop_data = slots[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && !do_push));
endmodule

// File: rtl/mem_req_port.sv
// rtl/mem_req_port.sv - credit-checked request issue toward the memory block with in-order tagged read responses
module mem_req_port
  import mem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAGW  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  input  logic [TAGW-1:0]   req_tag,
  output logic [ADDR_W-1:0] mem_rdaddr0,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_wraddr0,
  output logic [LINE_W-1:0] mem_wrdata,
  output logic              mem_wren,
  input  logic              mem_stall,
  input  logic              mem_rden_out,
  input  logic [LINE_W-1:0] mem_rddata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TAGW-1:0]   rsp_tag,
  output logic [LINE_W-1:0] rsp_data,
  output logic              err_orphan
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = TAGW + LINE_W;

  issue_t          issue_q, issue_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic            err_orphan_q, err_orphan_d;
  logic [CW-1:0]   tagq_count, rspq_count;
  logic            tagq_empty, rspq_empty;
  logic [TAGW-1:0] tagq_head;
  logic [RW-1:0]   rspq_head;
  logic [CW+1:0]   credit_used;
  logic            accept, tag_push, ret_valid, ret_ok, rd_consumed, rsp_pop;

  // Every read holds a credit from acceptance until its response leaves the response FIFO.
  always_comb begin
    credit_used = (CW+2)'(inflight_q) + (CW+2)'(rspq_count) + (CW+2)'(issue_q.rden);
    req_ready   = rst && !mem_stall && (credit_used < (CW+2)'(DEPTH));
    accept      = req_valid && req_ready;
    tag_push    = accept && !req_we;
    ret_valid   = mem_rden_out && !mem_stall;
    ret_ok      = ret_valid && !tagq_empty;
    rd_consumed = issue_q.rden && !mem_stall;
    rsp_pop     = !rspq_empty && rsp_ready;
  end

  always_comb begin
    issue_d = issue_q;
    if (!mem_stall) begin
      issue_d.rden = 1'b0;
      issue_d.wren = 1'b0;
      if (accept) begin
        if (req_we) begin
          issue_d.wren   = 1'b1;
          issue_d.wraddr = req_addr;
          issue_d.wrdata = req_wdata;
        end else begin
          issue_d.rden   = 1'b1;
          issue_d.rdaddr = req_addr;
        end
      end
    end
    inflight_d   = inflight_q + CW'(rd_consumed) - CW'(ret_ok);
    err_orphan_d = err_orphan_q || (ret_valid && tagq_empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_q      <= '0;
      inflight_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      issue_q      <= issue_d;
      inflight_q   <= inflight_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  req_fifo #(.W(TAGW), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (req_tag),
    .pop       (ret_ok),
    .pop_data  (tagq_head),
    .count     (tagq_count),
    .empty     (tagq_empty)
  );

  req_fifo #(.W(RW), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ret_ok),
    .push_data ({tagq_head, mem_rddata}),
    .pop       (rsp_pop),
    .pop_data  (rspq_head),
    .count     (rspq_count),
    .empty     (rspq_empty)
  );

  assign mem_rden    = issue_q.rden;
  assign mem_wren    = issue_q.wren;
  assign mem_rdaddr0 = issue_q.rdaddr;
  assign mem_wraddr0 = issue_q.wraddr;
  assign mem_wrdata  = issue_q.wrdata;
  assign rsp_valid   = !rspq_empty;
  assign rsp_tag     = rspq_head[RW-1:LINE_W];
  assign rsp_data    = rspq_head[LINE_W-1:0];
  assign err_orphan  = err_orphan_q;

  // Tags waiting are exactly the reads still in the issue register plus those inside memory.
  a_tag_track: assert property (@(posedge clk) disable iff (!rst)
    tagq_count == inflight_q + CW'(issue_q.rden));
endmodule

// File: doc/mem_req_port.md
MEM_REQ_PORT -- requirements
Module: mem_req_port

Interface
REQ-001 Parameter DEPTH, default 16: maximum number of outstanding reads; also the depth of the tag FIFO and the response FIFO; power of two, 2..64.
REQ-002 Parameter TAGW, default 6: width of the core request tag.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  1  core request present.
REQ-006 req_ready  out  1  request accepted this cycle when req_valid is also high.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  39  [37] share/intent flag, [36:4] line address, [3:0] xdata.
REQ-009 req_wdata  in  533  write payload.
REQ-010 req_tag  in  TAGW  read identifier, returned with the response.
REQ-011 mem_rdaddr0 / mem_rden  out  39 / 1  read address and read valid toward the memory block.
REQ-012 mem_wraddr0 / mem_wrdata / mem_wren  out  39 / 533 / 1  write address, write data and write valid toward the memory block.
REQ-013 mem_stall  in  1  memory pipeline frozen this cycle.
REQ-014 mem_rden_out / mem_rddata  in  1 / 533  read return from the memory block.
REQ-015 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-016 rsp_tag / rsp_data  out  TAGW / 533  response contents.
REQ-017 err_orphan  out  1  sticky flag: a read return arrived with no read outstanding.

Function
REQ-018 The memory-side outputs (mem_*) shall be driven from an issue register. Memory consumes the register at a rising edge where mem_stall=0. While mem_stall=1, the register shall hold its value unchanged.
REQ-019 req_ready shall equal !mem_stall && (inflight + rspq_count + issue_is_read) < DEPTH. This is credit-based, and the credit check applies to writes as well.
REQ-020 On req_valid && req_ready, the issue register shall load at the next edge.
REQ-020a For a read: mem_rdaddr0=req_addr, mem_rden=1, mem_wren=0, and req_tag is pushed into the tag FIFO.
REQ-020b For a write: mem_wraddr0=req_addr, mem_wrdata=req_wdata, mem_wren=1, mem_rden=0.
REQ-021 When mem_stall=0 and no request is accepted, the issue register shall load mem_rden=0 and mem_wren=0. Address and data fields keep their previous values.
REQ-022 inflight shall increment by 1 at each edge where a read is consumed (mem_rden && !mem_stall).
REQ-022a A return is valid only when mem_rden_out && !mem_stall; a held return during a stall shall not be counted twice.
REQ-023 On each valid return: inflight decrements by 1, the tag FIFO pops, and {tag, mem_rddata} is pushed into the response FIFO. The response FIFO is 1-cycle write-to-read.
REQ-024 A consumed read and a valid return in the same cycle shall leave inflight unchanged.
REQ-025 A tag-FIFO push and pop in the same cycle shall both take effect, including at full and empty.
REQ-026 rsp_valid shall be high whenever the response FIFO is non-empty, with rsp_tag/rsp_data at its head. The FIFO pops on rsp_valid && rsp_ready.
REQ-027 A response FIFO push and pop in the same cycle shall keep the count unchanged. FIFO pointers wrap modulo DEPTH.
REQ-028 Responses shall be delivered strictly in issue order.
REQ-029 A valid return while the tag FIFO is empty shall set err_orphan, shall be discarded, and shall leave all counts unchanged.
REQ-030 The credit rule guarantees neither FIFO overflows. An overflow is a design error and shall be covered by a simulation assertion.

Reset
REQ-031 While rst=0: mem_rden=0, mem_wren=0, mem_rdaddr0=0, mem_wraddr0=0, mem_wrdata=0.
REQ-032 While rst=0: inflight=0, both FIFOs empty, rsp_valid=0, err_orphan=0, and req_ready=0.
REQ-033 Returns still in the memory pipeline when reset is asserted mid-operation shall be flagged as orphans after reset; the system resets the memory block together with this block.

Structure
REQ-034 A shared package mem_pkg shall hold ADDR_W=39, LINE_W=533, the address-field bit positions and MEM_LAT=48.
REQ-035 A single sub-module, req_fifo (parameterised width and depth, async active-low reset, count output), shall be instantiated twice: once for tags and once for {tag,data}.

Verification
REQ-036 Single read (addr 39'h00_0000_1230, tag 5), no stall -> mem_rden high 1 cycle; memory model returns data D after 48 cycles -> rsp_valid with tag 5 and data D.
REQ-037 16 back-to-back reads with rsp_ready=0 -> req_ready drops after the 16th; all 16 responses delivered in order once rsp_ready=1, then req_ready returns to 1.
REQ-038 Write accepted while mem_stall=1 for 3 cycles -> mem_wren and mem_wraddr0 held stable for all 3 cycles, consumed exactly once.
REQ-039 mem_rden_out held high across a 4-cycle stall -> exactly 1 response pushed.
REQ-040 Return pulse with nothing outstanding -> err_orphan=1 and stays 1; no rsp_valid.
REQ-041 Reset asserted with 3 reads in flight -> all outputs at their reset values asynchronously; after release, req_ready=1 and counts=0.
